osc_edge_counter: RTL and testbench
===================================

// Module: osc_edge_counter
// PURPOSE
//  Counts rising edges of a buffered, asynchronous oscillator output over a
//  programmable window of CLK cycles and reports the total.
//  Sits directly downstream of the 9T drive-strength-8 buffer that carries
//  ring-oscillator/sensor outputs into the digital domain.
//  Provides the start/done measurement engine for generator digital back-ends.
// PARAMETERS
//  CNT_W        24  width of edge count result
//  WIN_W        16  width of window length (CLK cycles)
//  SYNC_STAGES   2  flops in osc_in synchronizer (>=2)
// PORTS
//  CLK      in   1      single clock; all state on rising edge
//  RST      in   1      synchronous, active-high reset
//  osc_in   in   1      buffered oscillator signal, asynchronous to CLK
//  start    in   1      request a measurement; sampled only in IDLE
//  win_len  in   WIN_W  window length in CLK cycles; latched when start accepted
//  busy     out  1      measurement in progress
//  done     out  1      one-cycle pulse; count/ovf valid
//  count    out  CNT_W  rising edges seen in window, saturating
//  ovf      out  1      count saturated during last window
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, count=0, ovf=0; synchronizer and edge
//   history cleared. RST has priority over every other input, any state.
//  osc_in is passed through SYNC_STAGES flops; a rising edge is one cycle
//   where the synced value=1 and the previous synced value=0. Exact counts
//   require osc_in period >= 2 CLK periods.
//  FSM: IDLE -> ARM -> COUNT -> DONE -> IDLE.
//   IDLE : start=1 -> latch win_len into win_cnt, go ARM.
//   ARM  : busy=1; clear count/ovf; prime edge history (any edge seen here is
//          discarded); win_cnt==0 -> DONE, else COUNT.
//   COUNT: each cycle add detected edge to count; decrement win_cnt; leave for
//          DONE on the cycle win_cnt==1 (edge in that cycle counts).
//          COUNT lasts exactly win_len cycles.
//   DONE : done=1 and busy=0 for exactly this cycle, then IDLE.
//  Timing: start sampled in cycle 0 -> busy=1 in cycles 1..win_len+1,
//   done=1 in cycle win_len+2.
//  Saturation: increment at count==all-ones holds count and sets ovf=1.
//   ovf stays set until the next ARM.
//  count/ovf hold their value from DONE until the next ARM.
//  start while busy or in DONE: ignored, not queued.
//  win_len changes after acceptance do not affect the running window.
//  osc_in idle (constant): count=0, ovf=0.
// STRUCTURE
//  Package osc_edge_counter_pkg: typedef enum logic [1:0] state_t
//   {ST_IDLE=0, ST_ARM=1, ST_COUNT=2, ST_DONE=3}; default CNT_W/WIN_W
//   localparams shared with the generator wrapper.
//  Sub-module osc_sync_edge: SYNC_STAGES synchronizer plus rising-edge
//   detector with a clear input (driven in ARM); output rise_pulse.
//  Top: FSM, window down-counter, saturating edge counter, output flops.
//  All outputs are registered.
// TESTING
//  1 RST=1 for 3 cycles with osc toggling -> busy=0, done=0, count=0, ovf=0.
//  2 osc period=10 CLK, win_len=100, start pulse -> done at start+102, count=10,
//    ovf=0, busy high for exactly 101 cycles.
//  3 CNT_W=4, osc period=4 CLK, win_len=100 -> count=15, ovf=1; next run with
//    osc held low, win_len=5 -> count=0, ovf=0.
//  4 win_len=0, start -> busy for 1 cycle, done at start+2, count=0.
//  5 start pulsed again at cycle 50 of a 100-cycle window -> single done at
//    start+102; count is the same as scenario 2.
//  6 RST asserted mid-COUNT -> next cycle busy=0, done=0, count=0; new start
//    afterwards -> scenario 2 result.

Source files
------------

// File: rtl/osc_edge_counter_pkg.sv
// Shared types and default widths for the oscillator edge counter and its
// generator wrapper.
package osc_edge_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int CNT_W_DEF       = 24;
  localparam int WIN_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/osc_sync_edge.sv
// Synchronizes the asynchronous oscillator into CLK and flags each rising
// edge for one cycle; clr masks the flag while the history is being primed.
module osc_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic osc_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // History keeps tracking during clr, so the first counted cycle compares
  // against a real previous sample rather than a stale one.
  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~prev_q & ~clr;

endmodule

// File: rtl/osc_edge_counter.sv
// Counts synchronized oscillator rising edges over a window of win_len CLK
// cycles, reporting a saturating count with an overflow flag.
module osc_edge_counter
  import osc_edge_counter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int WIN_W       = WIN_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             osc_in,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [WIN_W-1:0] win_cnt;
  logic             rise_pulse;

  osc_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (state == ST_ARM),
    .osc_in    (osc_in),
    .rise_pulse(rise_pulse)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      win_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      count   <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            win_cnt <= win_len;
            busy    <= 1'b1;
            state   <= ST_ARM;
          end
        end
        ST_ARM: begin
          count <= '0;
          ovf   <= 1'b0;
          if (win_cnt == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (rise_pulse) begin
            if (count == CNT_MAX) ovf <= 1'b1;
            else                  count <= count + CNT_W'(1);
          end
          win_cnt <= win_cnt - WIN_W'(1);
          // The edge sampled in the final window cycle is still counted above.
          if (win_cnt == WIN_W'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_osc_edge_counter.sv
// Directed bench: a full-width counter (a) and a 4-bit counter (b) for
// saturation, both driven from locally generated oscillators.
module tb_osc_edge_counter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        osc_a = 1'b0, osc_b = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [15:0] win_a = '0, win_b = '0;
  logic        busy_a, done_a, ovf_a;
  logic        busy_b, done_b, ovf_b;
  logic [23:0] count_a;
  logic [3:0]  count_b;

  int n_chk  = 0;
  int n_fail = 0;
  int half_a = 5;
  int half_b = 2;
  int ph_a   = 0;
  int ph_b   = 0;

  osc_edge_counter u_dut_a (
    .CLK(CLK), .RST(RST), .osc_in(osc_a), .start(start_a), .win_len(win_a),
    .busy(busy_a), .done(done_a), .count(count_a), .ovf(ovf_a)
  );

  osc_edge_counter #(.CNT_W(4)) u_dut_b (
    .CLK(CLK), .RST(RST), .osc_in(osc_b), .start(start_b), .win_len(win_b),
    .busy(busy_b), .done(done_b), .count(count_b), .ovf(ovf_b)
  );

  always #5 CLK = ~CLK;

  // Oscillators change 2 time units after each edge; half = 0 holds low.
  always @(posedge CLK) begin
    #2;
    if (half_a == 0) osc_a = 1'b0;
    else begin
      ph_a++;
      if (ph_a >= half_a) begin ph_a = 0; osc_a = ~osc_a; end
    end
    if (half_b == 0) osc_b = 1'b0;
    else begin
      ph_b++;
      if (ph_b >= half_b) begin ph_b = 0; osc_b = ~osc_b; end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Start dut a with window win; optionally re-pulse start at cycle restart
  // and change win_len mid-window. Checks done cycle, busy length, result.
  task automatic run_a(input string tag, input int win, input int restart,
                       input int exp_cnt, input int exp_ovf);
    int done_at = -1;
    int n_done  = 0;
    int n_busy  = 0;
    win_a   = 16'(win);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    win_a   = 16'd7;
    for (int n = 1; n <= win + 12; n++) begin
      start_a = (n == restart);
      if (busy_a) n_busy++;
      if (done_a) begin
        n_done++;
        if (done_at < 0) begin
          done_at = n;
          chk({tag, "_count"}, 32'(count_a), 32'(exp_cnt));
          chk({tag, "_ovf"}, 32'(ovf_a), 32'(exp_ovf));
          chk({tag, "_busy_at_done"}, 32'(busy_a), 32'd0);
        end
      end
      tick();
    end
    start_a = 1'b0;
    chk({tag, "_done_cycle"}, 32'(done_at), 32'(win + 2));
    chk({tag, "_done_pulses"}, 32'(n_done), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(n_busy), 32'(win + 1));
    chk({tag, "_count_hold"}, 32'(count_a), 32'(exp_cnt));
  endtask

  task automatic run_b(input string tag, input int win, input int exp_cnt, input int exp_ovf);
    int done_at = -1;
    win_b   = 16'(win);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int n = 1; n <= win + 6 && done_at < 0; n++) begin
      if (done_b) done_at = n;
      else tick();
    end
    chk({tag, "_done_cycle"}, 32'(done_at), 32'(win + 2));
    chk({tag, "_count"}, 32'(count_b), 32'(exp_cnt));
    chk({tag, "_ovf"}, 32'(ovf_b), 32'(exp_ovf));
    tick();
  endtask

  initial begin
    // 1: reset with oscillators toggling
    RST = 1'b1;
    repeat (3) tick();
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_count_a", 32'(count_a), 32'd0);
    chk("rst_ovf_a", 32'(ovf_a), 32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    chk("rst_count_b", 32'(count_b), 32'd0);
    RST = 1'b0;
    repeat (4) tick();

    // 2: period 10, window 100
    run_a("base", 100, -1, 10, 0);

    // 3: 4-bit counter saturates on 25 edges, then idle oscillator
    run_b("sat", 100, 15, 1);
    half_b = 0;
    repeat (4) tick();
    run_b("idle", 5, 0, 0);

    // 4: zero-length window
    run_a("win0", 0, -1, 0, 0);

    // 5: start pulsed mid-window is ignored
    run_a("restart", 100, 50, 10, 0);

    // 6: reset mid-COUNT, then a fresh measurement
    win_a   = 16'd100;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (40) tick();
    chk("pre_rst_busy", 32'(busy_a), 32'd1);
    RST = 1'b1;
    tick();
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_done", 32'(done_a), 32'd0);
    chk("mid_rst_count", 32'(count_a), 32'd0);
    RST = 1'b0;
    repeat (3) tick();
    run_a("post_rst", 100, -1, 10, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
